phase_freq_detector: RTL
========================

Name: phase_freq_detector

Overview:
- Parametrised successor to the single-bit XOR phase detector.
- Synchronises an asynchronous reference input and an asynchronous feedback input, then detects their rising edges.
- Runs a tri-state phase-frequency detector (PFD) state machine that drives UP/DN pulses and reports a signed phase error in clock cycles per measurement.
- Keeps a registered XOR output for legacy consumers and adds a lock indicator; sits between the signal front-end and the loop filter / control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input (min 2).
- CNT_W, 8, magnitude width of the phase counter; saturates at 2^CNT_W-1.
- LOCK_TOL, 1, max |phase_err| counted as in-lock.
- LOCK_CNT, 4, consecutive in-lock measurements required to assert locked (min 1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (clear on reset=0).
- en  in  1  detector enable.
- ref_in  in  1  asynchronous reference signal.
- fb_in  in  1  asynchronous feedback signal.
- up  out  1  high while ref leads (PFD UP state).
- dn  out  1  high while fb leads (PFD DN state).
- xor_out  out  1  registered XOR of the synchronised inputs.
- err_valid  out  1  one-cycle pulse when phase_err updates.
- phase_err  out  CNT_W+1  signed two's-complement error; +lead of ref, -lead of fb.
- slip  out  1  one-cycle pulse on cycle slip.
- locked  out  1  lock indicator.
- slip_count  out  16  slip counter (optional feature).
- slip_clr  in  1  clears slip_count (optional feature).

Behaviour:
- Reset (reset=0, async): all sync flops, edge history, state, counter, outputs and lock counter are 0; state=IDLE.
- Synchroniser: SYNC_STAGES flops per input.
- Edge detection: ref_edge = s_ref & ~s_ref_d, combinational from the last sync stage and a history flop; fb_edge likewise.
- Latency: an input rise first sampled at clock k gives an edge at k+SYNC_STAGES. up/dn/err_valid change one clock later.
- xor_out = registered (s_ref ^ s_fb), one clock after the sync stage.
- FSM states: IDLE, UP, DN. up=(state==UP) and dn=(state==DN), both decoded from registered state.
- IDLE:
  - ref_edge&fb_edge -> stay IDLE; err_valid=1, phase_err=0.
  - ref_edge only -> UP, cnt=1.
  - fb_edge only -> DN, cnt=1.
- UP, no edge: cnt increments, saturating at 2^CNT_W-1.
- UP, fb_edge only: -> IDLE; err_valid=1, phase_err=+cnt.
- UP, ref_edge only (second ref before fb): cycle slip.
  - slip=1; stay UP, cnt=1; no err_valid.
  - Lock counter cleared, locked=0.
- UP, both edges same cycle: err_valid=1, phase_err=+cnt; stay UP with cnt=1 (new measurement opened).
- DN: mirror image of UP with ref/fb swapped and negated sign (phase_err=-cnt).
- phase_err holds its value between err_valid pulses.
- Lock, evaluated on each err_valid:
  - |phase_err|<=LOCK_TOL -> lock_run increments, saturating at LOCK_CNT.
  - Otherwise lock_run=0 and locked=0.
  - locked=1 when lock_run reaches LOCK_CNT, effective the same cycle lock_run is written.
- en=0:
  - State forced IDLE, cnt=0.
  - up/dn/err_valid/slip=0; lock_run=0, locked=0.
  - phase_err holds its value.
  - Synchronisers and xor_out keep running.
- On en rising: edge history is already valid, so there is no spurious edge.
- Reset mid-measurement: immediate return to the reset values above, with no err_valid.

Optional Feature:
- Macro PD_SLIP_COUNT_EN.
- Defined:
  - slip_count is a 16-bit counter incrementing on every slip pulse, saturating at 0xFFFF.
  - slip_clr=1 clears it synchronously; clear wins over a simultaneous slip.
  - Reset clears it.
- Undefined: slip_count tied to 0, slip_clr ignored, no counter flops.

Test Plan (SYNC_STAGES=2, CNT_W=8, LOCK_TOL=1, LOCK_CNT=4 unless noted):
1. ref_in rises, fb_in rises 5 clocks later -> up high for exactly 5 cycles; one err_valid with phase_err=+5; dn never high.
2. fb_in rises, ref_in rises 3 clocks later -> dn high 3 cycles; phase_err=-3 (0x1FD in 9 bits).
3. Both inputs rise in the same cycle -> up=dn=0; err_valid with phase_err=0. Repeat 4 times -> locked=1 on the 4th err_valid; next measurement of +7 -> locked=0.
4. Two ref rises 10 clocks apart, fb stays low, then fb rises 4 clocks after the second ref -> slip pulse at the second ref edge; phase_err=+4; with PD_SLIP_COUNT_EN, slip_count=1, then slip_clr -> 0.
5. CNT_W=4, ref leads fb by 40 clocks -> phase_err=+15 (saturated).
6. Assert reset=0 while in UP with cnt=6 -> up, locked, phase_err and err_valid all 0 immediately; after release the next measurement starts from IDLE.

Source files
------------

// File: rtl/phase_freq_detector.sv
// phase_freq_detector: synchronised tri-state phase-frequency detector.
// Both asynchronous inputs pass through SYNC_STAGES flops. Their rising edges
// then drive an IDLE/UP/DN state machine, which reports a signed phase error
// in clock cycles. A registered XOR output is kept for legacy consumers, and a
// lock indicator is added.
// Optional build macro PD_SLIP_COUNT_EN adds a 16-bit saturating slip counter
// that slip_clr clears. Without the macro, slip_count is tied to zero.
module phase_freq_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic                    xor_out,
  output logic                    err_valid,
  output logic signed [CNT_W:0]   phase_err,
  output logic                    slip,
  output logic                    locked,
  output logic [15:0]             slip_count,
  input  logic                    slip_clr
);

  localparam int                    LRW      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [LRW-1:0]        LOCK_MAX = LRW'(LOCK_CNT);
  localparam logic signed [CNT_W:0] TOL      = (CNT_W + 1)'(LOCK_TOL);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} state_t;

  logic [SYNC_STAGES-1:0] ref_sync_p0, fb_sync_p0;
  logic                   ref_d_p1, fb_d_p1;
  logic                   s_ref, s_fb, ref_edge, fb_edge;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   err_valid_nxt, slip_nxt, locked_nxt;
  logic signed [CNT_W:0]  phase_err_nxt;
  logic [LRW-1:0]         lock_run, lock_run_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic within_tol(input logic signed [CNT_W:0] e);
    logic signed [CNT_W:0] mag;
    mag = e[CNT_W] ? -e : e;
    return mag <= TOL;
  endfunction

  assign s_ref    = ref_sync_p0[SYNC_STAGES-1];
  assign s_fb     = fb_sync_p0[SYNC_STAGES-1];
  assign ref_edge = s_ref & ~ref_d_p1;
  assign fb_edge  = s_fb & ~fb_d_p1;
  assign up       = (state == S_UP);
  assign dn       = (state == S_DN);

  // Synchronisers, edge history and legacy XOR keep running regardless of en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_sync_p0 <= '0;
      fb_sync_p0  <= '0;
      ref_d_p1    <= 1'b0;
      fb_d_p1     <= 1'b0;
      xor_out     <= 1'b0;
    end else begin
      ref_sync_p0 <= {ref_sync_p0[SYNC_STAGES-2:0], ref_in};
      fb_sync_p0  <= {fb_sync_p0[SYNC_STAGES-2:0], fb_in};
      ref_d_p1    <= s_ref;
      fb_d_p1     <= s_fb;
      xor_out     <= s_ref ^ s_fb;
    end
  end

  // PFD next-state, phase error measurement, slip and lock evaluation
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    err_valid_nxt = 1'b0;
    phase_err_nxt = phase_err;
    slip_nxt      = 1'b0;
    lock_run_nxt  = lock_run;
    locked_nxt    = locked;
    if (!en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ref_edge && fb_edge) begin
            err_valid_nxt = 1'b1;
            phase_err_nxt = '0;
          end else if (ref_edge) begin
            state_nxt = S_UP;
            cnt_nxt   = CNT_W'(1);
          end else if (fb_edge) begin
            state_nxt = S_DN;
            cnt_nxt   = CNT_W'(1);
          end
        end
        S_UP: begin
          if (fb_edge) begin
            err_valid_nxt = 1'b1;
            phase_err_nxt = $signed({1'b0, cnt});
            // A simultaneous ref edge opens the next measurement at once
            if (ref_edge) begin
              cnt_nxt = CNT_W'(1);
            end else begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end else if (ref_edge) begin
            slip_nxt = 1'b1;
            cnt_nxt  = CNT_W'(1);
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        S_DN: begin
          if (ref_edge) begin
            err_valid_nxt = 1'b1;
            phase_err_nxt = -$signed({1'b0, cnt});
            if (fb_edge) begin
              cnt_nxt = CNT_W'(1);
            end else begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end else if (fb_edge) begin
            slip_nxt = 1'b1;
            cnt_nxt  = CNT_W'(1);
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    if (!en || slip_nxt) begin
      lock_run_nxt = '0;
      locked_nxt   = 1'b0;
    end else if (err_valid_nxt) begin
      if (within_tol(phase_err_nxt)) begin
        lock_run_nxt = (lock_run == LOCK_MAX) ? lock_run : lock_run + LRW'(1);
      end else begin
        lock_run_nxt = '0;
      end
      locked_nxt = (lock_run_nxt == LOCK_MAX);
    end
  end

  // State, counter and registered detector outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_valid <= 1'b0;
      phase_err <= '0;
      slip      <= 1'b0;
      lock_run  <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      err_valid <= err_valid_nxt;
      phase_err <= phase_err_nxt;
      slip      <= slip_nxt;
      lock_run  <= lock_run_nxt;
      locked    <= locked_nxt;
    end
  end

`ifdef PD_SLIP_COUNT_EN
  // Saturating slip counter; a clear wins over a slip in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slip_count <= '0;
    end else if (slip_clr) begin
      slip_count <= '0;
    end else if (slip_nxt && (slip_count != 16'hFFFF)) begin
      slip_count <= slip_count + 16'd1;
    end
  end
`else
  logic unused_slip_clr;
  assign unused_slip_clr = slip_clr;
  assign slip_count      = 16'h0000;
`endif

endmodule
